// File: rtl/uart_rx_pkg.sv
// Shared types for the UART receive path.
// Frame states and parity type encodings.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversampling edge counter and bit counter.
// Edge index wraps at prescale-1; bit index steps on each wrap.
module uart_rx_edge_bit_cnt #(
  parameter int PRESC_W = 6,
  parameter int BCNT_W  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_i,
  input  logic               clr_i,
  input  logic [PRESC_W-1:0] presc_i,
  output logic [PRESC_W-1:0] edge_cnt_o,
  output logic [BCNT_W-1:0]  bit_cnt_o,
  output logic               bit_end_o
);

  logic [PRESC_W-1:0] edge_q, edge_d;
  logic [BCNT_W-1:0]  bit_q, bit_d;

  assign bit_end_o  = en_i && (edge_q == presc_i - PRESC_W'(1));
  assign edge_cnt_o = edge_q;
  assign bit_cnt_o  = bit_q;

  // Next counts: held at 0 when idle or when the frame ends.
  always_comb begin
    edge_d = edge_q + PRESC_W'(1);
    bit_d  = bit_q;
    if (!en_i || clr_i) begin
      edge_d = '0;
      bit_d  = '0;
    end else if (bit_end_o) begin
      edge_d = '0;
      bit_d  = bit_q + BCNT_W'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_q <= '0;
      bit_q  <= '0;
    end else begin
      edge_q <= edge_d;
      bit_q  <= bit_d;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller.
// Sequences start/data/parity/stop and flags frame errors.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESC_W-1:0]    Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  sampled_bit,
  output logic                  data_samp_en,
  output logic [PRESC_W-1:0]    edge_cnt,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int BCNT_W = $clog2(DATA_WIDTH + 4);

  rx_state_e             state_q;
  logic [PRESC_W-1:0]    presc_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  frm_err_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] pdata_q;
  logic                  samp_en_q;
  logic                  valid_q;
  logic                  par_err_q;
  logic                  stp_err_q;

  logic                  cnt_en;
  logic                  cnt_clr;
  logic                  bit_end;
  logic [BCNT_W-1:0]     bit_cnt;
  logic                  par_exp;

  assign cnt_en  = (state_q != IDLE);
  assign cnt_clr = bit_end &&
                   ((state_q == STOP) ||
                    ((state_q == START) && sampled_bit));
  assign par_exp = (^shift_q) ^ (par_typ_q == PAR_ODD);

  uart_rx_edge_bit_cnt #(
    .PRESC_W (PRESC_W),
    .BCNT_W  (BCNT_W)
  ) u_cnt (
    .clk        (CLK),
    .rst_n      (RST),
    .en_i       (cnt_en),
    .clr_i      (cnt_clr),
    .presc_i    (presc_q),
    .edge_cnt_o (edge_cnt),
    .bit_cnt_o  (bit_cnt),
    .bit_end_o  (bit_end)
  );

  // Frame FSM with deserializer, checks and registered outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      frm_err_q <= 1'b0;
      shift_q   <= '0;
      pdata_q   <= '0;
      samp_en_q <= 1'b0;
      valid_q   <= 1'b0;
      par_err_q <= 1'b0;
      stp_err_q <= 1'b0;
    end else begin
      valid_q   <= 1'b0;
      par_err_q <= 1'b0;
      stp_err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!RX_IN) begin
            state_q   <= START;
            samp_en_q <= 1'b1;
            presc_q   <= Prescale;
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
            frm_err_q <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            if (sampled_bit) begin
              state_q   <= IDLE;
              samp_en_q <= 1'b0;
            end else begin
              state_q <= DATA;
            end
          end
        end
        DATA: begin
          if (bit_end) begin
            shift_q <= {sampled_bit, shift_q[DATA_WIDTH-1:1]};
            if (bit_cnt == BCNT_W'(DATA_WIDTH)) begin
              state_q <= par_en_q ? PARITY : STOP;
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state_q <= STOP;
            if (sampled_bit != par_exp) begin
              par_err_q <= 1'b1;
              frm_err_q <= 1'b1;
            end
          end
        end
        STOP: begin
          if (bit_end) begin
            state_q   <= IDLE;
            samp_en_q <= 1'b0;
            if (!sampled_bit) begin
              stp_err_q <= 1'b1;
            end else if (!frm_err_q) begin
              pdata_q <= shift_q;
              valid_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          samp_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign data_samp_en = samp_en_q;
  assign P_DATA       = pdata_q;
  assign data_valid   = valid_q;
  assign par_err      = par_err_q;
  assign stp_err      = stp_err_q;

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Frame controller for the UART receiver. Detects the start bit, generates the per-bit oversampling edge count and the sample-enable for the majority-vote data sampler, and consumes its `sampled_bit`. It sequences start, data, optional parity and stop bits, deserializes LSB-first into `P_DATA`, checks parity and stop, and pulses `data_valid` for each good frame. It sits between `RX_IN` and the RX-side synchronizer and register interface, in the UART clock domain.

Parameters:
DATA_WIDTH, 8, number of data bits per frame
PRESC_W, 6, width of Prescale and edge_cnt

Ports:
CLK  in  1  UART RX oversampling clock
RST  in  1  asynchronous active-low reset
RX_IN  in  1  serial line, idle high (already synchronized)
Prescale  in  PRESC_W  oversampling ratio; legal values are 8, 16 and 32
PAR_EN  in  1  1 = parity bit present
PAR_TYP  in  1  0 = even, 1 = odd
sampled_bit  in  1  majority-voted bit from the sampler
data_samp_en  out  1  enables the sampler
edge_cnt  out  PRESC_W  oversampling edge index within the current bit
P_DATA  out  DATA_WIDTH  last received data word
data_valid  out  1  one-cycle pulse for a good frame
par_err  out  1  one-cycle pulse on parity mismatch
stp_err  out  1  one-cycle pulse when the stop bit is 0

Behaviour:
- Reset (RST low, async): state = IDLE; edge_cnt = 0; bit counter = 0; data_samp_en = 0; P_DATA = 0; data_valid = 0; par_err = 0; stp_err = 0. Reset mid-frame aborts the frame with no pulses.
- States: IDLE, START, DATA, PARITY, STOP.
- Edge and bit counters:
  - Held at 0 in IDLE.
  - Outside IDLE, edge_cnt increments every cycle and wraps from Prescale-1 to 0.
  - The bit counter increments on each wrap.
  - The last edge of a bit is `bit_end` = (edge_cnt == Prescale-1).
- data_samp_en = 1 in every state except IDLE. It is a registered output, consistent with the state.
- Every bit decision uses `sampled_bit` at bit_end. This gives the sampler time to capture its three mid-bit samples and register the vote.
- IDLE: if RX_IN == 0, go to START on the next cycle. The first START cycle has edge_cnt = 0.
- START: at bit_end, if sampled_bit == 1, treat it as a glitch: return to IDLE with no error pulse. Otherwise go to DATA.
- DATA:
  - At each bit_end, shift sampled_bit into the shift register MSB-first, so the first data bit ends in bit 0 (LSB-first on the line).
  - After DATA_WIDTH bits, go to PARITY if PAR_EN = 1, else to STOP.
- PARITY: at bit_end, the expected bit is XOR of the shift register, XORed with PAR_TYP.
  - On mismatch, pulse par_err for 1 cycle and latch a frame error flag.
  - Go to STOP in either case.
- STOP: at bit_end, go to IDLE.
  - If sampled_bit == 0, pulse stp_err for 1 cycle and drop the frame.
  - Else, if no parity error is latched, load P_DATA from the shift register and pulse data_valid for 1 cycle. Both are registered in the cycle after bit_end.
- P_DATA holds its value until the next good frame. Errored frames never update it.
- PAR_EN, PAR_TYP and Prescale are sampled in IDLE at start detection and held for the whole frame. Changes mid-frame have no effect.
- Back-to-back frames: RX_IN low on the first IDLE cycle after STOP starts a new frame, with no dead time beyond that cycle.
- Latency: data_valid occurs 1 cycle after the stop bit's bit_end. Total frame length is (1 + DATA_WIDTH + PAR_EN + 1) × Prescale + 1 cycles from start detection.
- Illegal Prescale values give undefined timing. There is no internal check.

Decomposition:
- Shared package `uart_rx_pkg`:
  - state enum (IDLE/START/DATA/PARITY/STOP);
  - parity type constants PAR_EVEN = 0, PAR_ODD = 1.
- One sub-module, `uart_rx_edge_bit_cnt`. It holds edge_cnt and the bit counter, with enable, Prescale and bit_end outputs.
- The FSM, deserializer and checks stay in `uart_rx_ctrl`. The existing sampler is instantiated beside it at the top level, not inside it.

Test Plan:
- Prescale = 8, PAR_EN = 1, PAR_TYP = 0, send 0xA5 with parity 0 and stop 1 → data_valid pulses once 1 cycle after stop bit_end; P_DATA = 0xA5; par_err = 0; stp_err = 0.
- Prescale = 16, PAR_EN = 1, PAR_TYP = 1, send 0x3C with parity bit 0 (wrong; odd parity requires 1) → par_err pulses at parity bit_end; no data_valid; P_DATA keeps its previous value.
- Prescale = 32, PAR_EN = 0, send 0x5A with stop bit 0 → stp_err pulses 1 cycle; no data_valid; FSM returns to IDLE.
- RX_IN low for 3 cycles then high (Prescale = 8) → FSM returns to IDLE after the start bit_end; no pulses; P_DATA unchanged.
- Two back-to-back frames 0x01 then 0xFF (Prescale = 8, no parity) → two data_valid pulses spaced 10 × 8 + 1 cycles apart; P_DATA shows 0x01 then 0xFF.
- Assert RST during DATA of frame 0x77 → all outputs return to their reset values immediately; a following frame 0x12 is received correctly.
